// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk_base cycles,
// publishing one measurement per input period and flagging stalled inputs.
module clk_period_meter #(
  parameter int unsigned nBit = 18
) (
  input  logic            clk_base,
  input  logic            reset,
  input  logic            stop,
  input  logic            clk_in,
  output logic [nBit-1:0] period,
  output logic [nBit-1:0] high_time,
  output logic            valid,
  output logic            locked,
  output logic            timeout
);

  localparam logic [nBit-1:0] CNT_MAX   = '1;
  localparam logic [nBit-1:0] CNT_STALL = CNT_MAX - nBit'(1);
  localparam logic [nBit-1:0] CNT_ONE   = nBit'(1);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise;

  state_e          state_q, state_d;
  logic [nBit-1:0] cnt_q, cnt_d;
  logic [nBit-1:0] hcnt_q, hcnt_d;
  logic [nBit-1:0] period_q, period_d;
  logic [nBit-1:0] high_time_q, high_time_d;
  logic            valid_q, valid_d;
  logic            locked_q, locked_d;
  logic            timeout_q, timeout_d;
  logic [nBit-1:0] cnt_inc;
  logic [nBit-1:0] hcnt_inc;

  // Synchronizer and edge history keep running through stop.
  always_comb begin
    s1_d = clk_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk_base) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Saturating increments; the high counter only advances while the input is high.
  always_comb begin
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    hcnt_inc = (s2_q && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_ONE : hcnt_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;

    if (stop) begin
      state_d   = ST_ARM;
      cnt_d     = '0;
      hcnt_d    = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARM: begin
          cnt_d  = '0;
          hcnt_d = '0;
          if (rise) begin
            state_d = ST_RUN;
            hcnt_d  = CNT_ONE;
          end
        end
        ST_RUN: begin
          if (rise) begin
            period_d    = cnt_q + CNT_ONE;
            high_time_d = hcnt_q;
            valid_d     = 1'b1;
            locked_d    = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = '0;
            hcnt_d      = CNT_ONE;
          end else if (cnt_q == CNT_STALL) begin
            // Freeze before cnt can reach all-ones so cnt+1 never overflows.
            state_d   = ST_STALL;
            timeout_d = 1'b1;
          end else begin
            cnt_d  = cnt_inc;
            hcnt_d = hcnt_inc;
          end
        end
        ST_STALL: begin
          // The stalled interval is discarded; the next rise restarts a fresh period.
          if (rise) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            hcnt_d  = CNT_ONE;
          end
        end
        default: begin
          state_d = ST_ARM;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_base) begin
    if (reset) begin
      state_q     <= ST_ARM;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: two instances (18-bit and 6-bit counters)
// share one phase-locked stimulus stream.
module tb_clk_period_meter;

  logic        clk_base = 1'b0;
  logic        reset    = 1'b1;
  logic        stop     = 1'b0;
  logic        clk_in   = 1'b0;
  logic [17:0] period, high_time;
  logic        valid, locked, timeout;
  logic [5:0]  period6, high_time6;
  logic        valid6, locked6, timeout6;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_v = -1;
  int last_v6 = -1;
  int vcount = 0;
  int vcount6 = 0;
  bit chk_en = 1'b0;
  int exp_per = 0;
  int exp_hi = 0;
  int exp_space = 0;

  clk_period_meter #(.nBit(18)) u_dut (
    .clk_base(clk_base), .reset(reset), .stop(stop), .clk_in(clk_in),
    .period(period), .high_time(high_time), .valid(valid),
    .locked(locked), .timeout(timeout)
  );

  clk_period_meter #(.nBit(6)) u_dut6 (
    .clk_base(clk_base), .reset(reset), .stop(stop), .clk_in(clk_in),
    .period(period6), .high_time(high_time6), .valid(valid6),
    .locked(locked6), .timeout(timeout6)
  );

  always #5 clk_base = ~clk_base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One base cycle with clk_in driven to v; outputs sampled 1 ns after the edge.
  task automatic cycle(input bit v);
    clk_in = v;
    @(posedge clk_base);
    #1;
    cyc++;
    if (valid) begin
      vcount++;
      if (chk_en) begin
        check("period", 32'(period), 32'(exp_per));
        check("high_time", 32'(high_time), 32'(exp_hi));
        if (last_v >= 0) check("valid_spacing", 32'(cyc - last_v), 32'(exp_space));
      end
      last_v = cyc;
    end
    if (valid6) begin
      vcount6++;
      if (chk_en) begin
        check("period6", 32'(period6), 32'(exp_per));
        check("high_time6", 32'(high_time6), 32'(exp_hi));
      end
      last_v6 = cyc;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    exp_per   = hi + lo;
    exp_hi    = hi;
    exp_space = hi + lo;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) cycle(1'b1);
      for (int i = 0; i < lo; i++) cycle(1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_high_time"}, 32'(high_time), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_period6"}, 32'(period6), 32'd0);
  endtask

  initial begin
    // Power-on reset.
    reset = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    check_reset_vals("por");
    reset = 1'b0;

    // 5/5 toggle: four rises yield three measurements.
    chk_en = 1'b1;
    vcount = 0;
    wave(5, 5, 4);
    check("toggle5_count", 32'(vcount), 32'd3);
    check("toggle5_locked", 32'(locked), 32'd1);

    // Reset mid-RUN, then the first valid comes on the second rise.
    reset = 1'b1;
    cycle(1'b0);
    check_reset_vals("midrun_reset");
    reset = 1'b0;
    last_v = -1;
    vcount = 0;
    wave(5, 5, 1);
    check("after_reset_first_rise", 32'(vcount), 32'd0);
    wave(5, 5, 2);
    check("after_reset_count", 32'(vcount), 32'd2);

    // Divider pattern 3 high / 7 low; first valid still describes the 5/5 period.
    chk_en = 1'b0;
    wave(3, 7, 1);
    chk_en = 1'b1;
    vcount = 0;
    wave(3, 7, 5);
    check("div_count", 32'(vcount), 32'd5);
    check("div_locked", 32'(locked), 32'd1);

    // Stop held 20 cycles while the input keeps toggling.
    vcount = 0;
    stop = 1'b1;
    cycle(1'b1);
    check("stop_locked", 32'(locked), 32'd0);
    check("stop_timeout", 32'(timeout), 32'd0);
    check("stop_period_hold", 32'(period), 32'd10);
    check("stop_high_hold", 32'(high_time), 32'd3);
    cycle(1'b1);
    cycle(1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0);
    wave(3, 7, 1);
    check("stop_no_valid", 32'(vcount), 32'd0);
    stop = 1'b0;
    last_v = -1;
    wave(3, 7, 1);
    check("release_first_rise", 32'(vcount), 32'd0);
    wave(3, 7, 1);
    check("release_second_rise", 32'(vcount), 32'd1);
    check("release_locked", 32'(locked), 32'd1);

    // Stall on the 6-bit instance: timeout 63 edges after the last valid edge.
    chk_en = 1'b0;
    while (cyc < last_v6 + 62) cycle(1'b0);
    check("stall_timeout_early", 32'(timeout6), 32'd0);
    cycle(1'b0);
    check("stall_timeout_set", 32'(timeout6), 32'd1);
    check("stall_period_hold", 32'(period6), 32'd10);
    check("stall_wide_no_timeout", 32'(timeout), 32'd0);
    vcount6 = 0;
    wave(6, 6, 1);
    check("stall_first_rise_no_valid", 32'(vcount6), 32'd0);
    check("stall_timeout_sticky", 32'(timeout6), 32'd1);
    wave(6, 6, 1);
    check("stall_recover_count", 32'(vcount6), 32'd1);
    check("stall_recover_period", 32'(period6), 32'd12);
    check("stall_recover_high", 32'(high_time6), 32'd6);
    check("stall_recover_timeout", 32'(timeout6), 32'd0);

    // Minimum period: toggle every cycle after a re-arm.
    stop = 1'b1;
    cycle(1'b0);
    stop = 1'b0;
    last_v = -1;
    vcount = 0;
    chk_en = 1'b1;
    wave(1, 1, 10);
    check("minper_count", 32'(vcount), 32'd8);
    check("minper_locked", 32'(locked), 32'd1);

    // A rise is pending right now; stop on the same edge must win.
    vcount = 0;
    stop = 1'b1;
    cycle(1'b0);
    check("stop_rise_valid", 32'(valid), 32'd0);
    check("stop_rise_locked", 32'(locked), 32'd0);
    check("stop_rise_period", 32'(period), 32'd2);
    stop = 1'b0;
    last_v = -1;
    wave(4, 4, 2);
    check("stop_rise_rearm_count", 32'(vcount), 32'd1);

    // Reset and stop together: reset values, including period.
    reset = 1'b1;
    stop  = 1'b1;
    cycle(1'b0);
    check_reset_vals("reset_stop");
    reset = 1'b0;
    stop  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
